// File: rtl/fft_bfly_r2_pipe.sv
// fft_bfly_r2_pipe: 3-stage pipelined radix-2 DIT butterfly on signed
// fixed-point complex data, X0 = A + B*W, X1 = A - B*W, with valid/ready
// streaming and a sticky saturation flag.
// Build macro FFT_BFLY_ROUND_EN: round half-up on every reduction; when
// undefined, reductions truncate toward -inf.
module fft_bfly_r2_pipe #(
  parameter int INT_BITS    = 8,
  parameter int FRAC_BITS   = 8,
  parameter int TW_INT_BITS = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic                                       in_scale,
  input  logic signed [INT_BITS+FRAC_BITS-1:0]       a_re,
  input  logic signed [INT_BITS+FRAC_BITS-1:0]       a_im,
  input  logic signed [INT_BITS+FRAC_BITS-1:0]       b_re,
  input  logic signed [INT_BITS+FRAC_BITS-1:0]       b_im,
  input  logic signed [TW_INT_BITS+FRAC_BITS-1:0]    w_re,
  input  logic signed [TW_INT_BITS+FRAC_BITS-1:0]    w_im,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic signed [INT_BITS+FRAC_BITS-1:0]       x0_re,
  output logic signed [INT_BITS+FRAC_BITS-1:0]       x0_im,
  output logic signed [INT_BITS+FRAC_BITS-1:0]       x1_re,
  output logic signed [INT_BITS+FRAC_BITS-1:0]       x1_im,
  output logic                                       ovf_sticky,
  input  logic                                       ovf_clr
);

  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int TW = TW_INT_BITS + FRAC_BITS;
  localparam int PW = W + TW;

`ifdef FFT_BFLY_ROUND_EN
  localparam logic [PW+1:0] RND_T = (PW+2)'(1) << (FRAC_BITS - 1);
`endif

  // Reduce a product sum by FRAC_BITS and saturate to W+1 bits.
  // Returns {overflow, value}; widened by one bit so the rounding add cannot wrap.
  function automatic logic [W+1:0] reduce_t(input logic signed [PW:0] t);
    logic signed [PW+1:0] v;
    logic [W:0]           q;
    logic                 o;
    v = {t[PW], t};
`ifdef FFT_BFLY_ROUND_EN
    v = v + RND_T;
`endif
    v = v >>> FRAC_BITS;
    o = (v[PW+1:W] != {(PW+2-W){v[W]}});
    if (!o)
      q = v[W:0];
    else if (v[PW+1])
      q = {1'b1, {W{1'b0}}};
    else
      q = {1'b0, {W{1'b1}}};
    return {o, q};
  endfunction

  // Form A +/- t at W+2 bits, optionally halve, saturate to W.
  // Returns {overflow, value}.
  function automatic logic [W:0] combine(input logic signed [W-1:0] a,
                                         input logic signed [W:0]   t,
                                         input logic                sub,
                                         input logic                sc);
    logic signed [W+1:0] s;
    logic signed [W+2:0] v;
    logic [W-1:0]        q;
    logic                o;
    if (sub)
      s = {{2{a[W-1]}}, a} - {t[W], t};
    else
      s = {{2{a[W-1]}}, a} + {t[W], t};
    v = {s[W+1], s};
    if (sc) begin
`ifdef FFT_BFLY_ROUND_EN
      v = v + (W+3)'(1);
`endif
      v = v >>> 1;
    end
    o = (v[W+2:W-1] != {4{v[W-1]}});
    if (!o)
      q = v[W-1:0];
    else if (v[W+2])
      q = {1'b1, {(W-1){1'b0}}};
    else
      q = {1'b0, {(W-1){1'b1}}};
    return {o, q};
  endfunction

  logic w_adv;

  logic                 r_v1, r_sc1;
  logic signed [PW-1:0] r_prr, r_pii, r_pri, r_pir;
  logic signed [W-1:0]  r_a1_re, r_a1_im;

  logic                 r_v2, r_sc2, r_ovf2;
  logic signed [W:0]    r_t_re, r_t_im;
  logic signed [W-1:0]  r_a2_re, r_a2_im;

  logic                 r_v3, r_ovf3, r_sticky;
  logic signed [W-1:0]  r_x0_re, r_x0_im, r_x1_re, r_x1_im;

  logic signed [PW-1:0] w_b_re, w_b_im, w_tw_re, w_tw_im;
  logic signed [PW:0]   w_sum_re, w_sum_im;
  logic [W+1:0]         w_red_re, w_red_im;
  logic [W:0]           w_c0_re, w_c0_im, w_c1_re, w_c1_im;

  // Whole pipeline moves together; it only holds while a result waits at the output.
  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign x0_re     = r_x0_re;
  assign x0_im     = r_x0_im;
  assign x1_re     = r_x1_re;
  assign x1_im     = r_x1_im;
  assign ovf_sticky = r_sticky;

  // Operand sign extension, stage-2 sum/reduction and stage-3 combine.
  always_comb begin
    w_b_re   = PW'(b_re);
    w_b_im   = PW'(b_im);
    w_tw_re  = PW'(w_re);
    w_tw_im  = PW'(w_im);
    w_sum_re = {r_prr[PW-1], r_prr} - {r_pii[PW-1], r_pii};
    w_sum_im = {r_pri[PW-1], r_pri} + {r_pir[PW-1], r_pir};
    w_red_re = reduce_t(w_sum_re);
    w_red_im = reduce_t(w_sum_im);
    w_c0_re  = combine(r_a2_re, r_t_re, 1'b0, r_sc2);
    w_c0_im  = combine(r_a2_im, r_t_im, 1'b0, r_sc2);
    w_c1_re  = combine(r_a2_re, r_t_re, 1'b1, r_sc2);
    w_c1_im  = combine(r_a2_im, r_t_im, 1'b1, r_sc2);
  end

  // Stage 1: register the four partial products, A and the scale mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_sc1   <= 1'b0;
      r_prr   <= '0;
      r_pii   <= '0;
      r_pri   <= '0;
      r_pir   <= '0;
      r_a1_re <= '0;
      r_a1_im <= '0;
    end else if (w_adv) begin
      r_v1    <= in_valid;
      r_sc1   <= in_scale;
      r_prr   <= w_b_re * w_tw_re;
      r_pii   <= w_b_im * w_tw_im;
      r_pri   <= w_b_re * w_tw_im;
      r_pir   <= w_b_im * w_tw_re;
      r_a1_re <= a_re;
      r_a1_im <= a_im;
    end
  end

  // Stage 2: register the reduced complex product t = B*W and its overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_sc2   <= 1'b0;
      r_ovf2  <= 1'b0;
      r_t_re  <= '0;
      r_t_im  <= '0;
      r_a2_re <= '0;
      r_a2_im <= '0;
    end else if (w_adv) begin
      r_v2    <= r_v1;
      r_sc2   <= r_sc1;
      r_ovf2  <= r_v1 && (w_red_re[W+1] || w_red_im[W+1]);
      r_t_re  <= w_red_re[W:0];
      r_t_im  <= w_red_im[W:0];
      r_a2_re <= r_a1_re;
      r_a2_im <= r_a1_im;
    end
  end

  // Stage 3: output registers, with the sample's accumulated overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3    <= 1'b0;
      r_ovf3  <= 1'b0;
      r_x0_re <= '0;
      r_x0_im <= '0;
      r_x1_re <= '0;
      r_x1_im <= '0;
    end else if (w_adv) begin
      r_v3    <= r_v2;
      r_ovf3  <= r_v2 && (r_ovf2 || w_c0_re[W] || w_c0_im[W] ||
                          w_c1_re[W] || w_c1_im[W]);
      r_x0_re <= w_c0_re[W-1:0];
      r_x0_im <= w_c0_im[W-1:0];
      r_x1_re <= w_c1_re[W-1:0];
      r_x1_im <= w_c1_im[W-1:0];
    end
  end

  // Sticky overflow: set when a saturated sample is handed off, clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sticky <= 1'b0;
    else if (ovf_clr)
      r_sticky <= 1'b0;
    else if (r_v3 && out_ready && r_ovf3)
      r_sticky <= 1'b1;
  end

endmodule
